// File: rtl/ex_alu_stage.sv
// ex_alu_stage: registered 64-bit execute stage (AND/OR/ADD/SUB) with valid/ready
// handshake and a one-entry skid buffer so in_ready comes straight from a flop.
module or_unit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] y
);
    assign y = a | b;
endmodule

module ex_alu_stage #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [3:0]      in_alu_ctrl,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_reg_write,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic [RD_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_illegal
);
    // entry layout: {result, zero, rd, reg_write, illegal}
    localparam int W = XLEN + RD_W + 3;

    logic [W-1:0]    out_d, out_q, skid_d, skid_q, in_entry;
    logic            out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
    logic [XLEN-1:0] or_y, res;
    logic            ill, acc, xfer;

    or_unit u_or (.a(in_a), .b(in_b), .y(or_y));

    always_comb begin
        res = in_alu_ctrl == 4'b0000 ? in_a & in_b :
              in_alu_ctrl == 4'b0001 ? or_y :
              in_alu_ctrl == 4'b0010 ? in_a + in_b :
              in_alu_ctrl == 4'b0110 ? in_a + ~in_b + XLEN'(1) : '0;
        ill = !(in_alu_ctrl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110});
        in_entry = {res, res == '0, in_rd, in_reg_write & ~ill, ill};
    end

    always_comb begin
        acc          = in_valid && !skid_valid_q && !flush;
        xfer         = out_valid_q && out_ready;
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || xfer) begin
            out_valid_d  = skid_valid_q || acc;
            out_d        = skid_valid_q ? skid_q : acc ? in_entry : out_q;
            skid_valid_d = 1'b0;
        end else if (acc) begin
            skid_valid_d = 1'b1;
            skid_d       = in_entry;
        end
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready      = !skid_valid_q;
    assign out_valid     = out_valid_q;
    assign out_result    = out_q[W-1 -: XLEN];
    assign out_zero      = out_q[RD_W+2];
    assign out_rd        = out_q[RD_W+1:2];
    assign out_reg_write = out_q[1];
    assign out_illegal   = out_q[0];
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed vectors plus random stress, checked by a scoreboard
// queue filled on acceptance and drained by a monitor on each output transfer.
module tb_ex_alu_stage;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0, in_reg_write = 0;
    logic [63:0] in_a = 0, in_b = 0;
    logic [3:0]  in_alu_ctrl = 0;
    logic [4:0]  in_rd = 0;
    logic        in_ready, out_valid, out_zero, out_reg_write, out_illegal;
    logic [63:0] out_result;
    logic [4:0]  out_rd;

    typedef struct packed {
        logic [63:0] r;
        logic        z;
        logic [4:0]  rd;
        logic        rw;
        logic        il;
    } exp_t;

    exp_t sbq[$];
    exp_t exp_cur;
    int   checks = 0, errors = 0, delivered = 0;

    ex_alu_stage #(.XLEN(64), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_alu_ctrl(in_alu_ctrl),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] ctrl, input logic [4:0] rd, input logic rw);
        exp_t e;
        e.il = 1'b0;
        case (ctrl)
            4'h0: e.r = a & b;
            4'h1: e.r = a | b;
            4'h2: e.r = a + b;
            4'h6: e.r = a - b;
            default: begin e.r = '0; e.il = 1'b1; end
        endcase
        e.z  = (e.r == 0);
        e.rd = rd;
        e.rw = rw && !e.il;
        return e;
    endfunction

    // stimulus side: record what an accepted op must produce
    always @(negedge clk)
        if (rst_n && in_valid && in_ready && !flush) sbq.push_back(exp_cur);

    // monitor: compare every completed transfer, then apply flush
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                delivered++;
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: unexpected output %h rd=%0d", out_result, out_rd);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checks++;
                    if ({out_result, out_zero, out_rd, out_reg_write, out_illegal} !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got r=%h z=%b rd=%0d rw=%b il=%b expected r=%h z=%b rd=%0d rw=%b il=%b",
                                 out_result, out_zero, out_rd, out_reg_write, out_illegal,
                                 e.r, e.z, e.rd, e.rw, e.il);
                    end
                end
            end
            if (flush) sbq.delete();
        end
    end

    always @(negedge rst_n) sbq.delete();

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctrl,
                         input logic [4:0] rd, input logic rw,
                         input logic [63:0] er, input logic eil, input logic erw);
        in_valid = 1; in_a = a; in_b = b; in_alu_ctrl = ctrl; in_rd = rd; in_reg_write = rw;
        exp_cur = '{r: er, z: (er == 0), rd: rd, rw: erw, il: eil};
    endtask

    task automatic wait_acc(input string name);
        logic ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: accept timeout got in_ready=0 expected 1", name);
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [3:0] ctrl,
                        input logic [4:0] rd, input logic rw,
                        input logic [63:0] er, input logic eil, input logic erw);
        drive(a, b, ctrl, rd, rw, er, eil, erw);
        wait_acc("send");
    endtask

    task automatic op_lat(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] ctrl, input logic [4:0] rd, input logic rw,
                          input logic [63:0] er, input logic eil, input logic erw);
        send(a, b, ctrl, rd, rw, er, eil, erw);
        @(negedge clk);
        chk({name, " valid"}, out_valid, 1);
        chk({name, " result"}, out_result, er);
        chk({name, " zero"}, out_zero, er == 0);
        chk({name, " illegal"}, out_illegal, eil);
        chk({name, " reg_write"}, out_reg_write, erw);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic last_acc, last_fl;
        logic [3:0] ctrls [6];
        ctrls = '{4'h0, 4'h1, 4'h2, 4'h6, 4'hF, 4'h9};

        #12;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_zero", out_zero, 0);
        chk("reset out_rd", out_rd, 0);
        chk("reset out_reg_write", out_reg_write, 0);
        chk("reset out_illegal", out_illegal, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("in_ready after reset", in_ready, 1);
        @(posedge clk); #1;

        out_ready = 1;
        op_lat("or",  64'hFFFF0000FFFF0000, 64'h00FF00FF00FF00FF, 4'b0001, 5'd1, 1, 64'hFFFF00FFFFFF00FF, 0, 1);
        op_lat("and", 64'hFFFF0000FFFF0000, 64'h00FF00FF00FF00FF, 4'b0000, 5'd2, 1, 64'h00FF000000FF0000, 0, 1);
        op_lat("add", 64'hFFFFFFFFFFFFFFFF, 64'd1, 4'b0010, 5'd3, 1, 64'd0, 0, 1);
        op_lat("sub", 64'd5, 64'd7, 4'b0110, 5'd4, 0, 64'hFFFFFFFFFFFFFFFE, 0, 0);
        op_lat("illegal", 64'd123, 64'd456, 4'b1111, 5'd5, 1, 64'd0, 1, 0);

        // backpressure: A held, B in skid, C stalled
        out_ready = 0;
        d0 = delivered;
        send(64'd1, 64'd2, 4'b0010, 5'd10, 1, 64'd3, 0, 1);
        #1 out_ready = 1;
        #1 chk("in_ready vs out_ready (skid empty)", in_ready, 1);
        out_ready = 0;
        send(64'd10, 64'd3, 4'b0110, 5'd11, 1, 64'd7, 0, 1);
        drive(64'hF0, 64'h3C, 4'b0000, 5'd12, 1, 64'h30, 0, 1);
        #1 out_ready = 1;
        #1 chk("in_ready vs out_ready (skid full)", in_ready, 0);
        out_ready = 0;
        repeat (2) begin
            @(negedge clk);
            chk("bp in_ready", in_ready, 0);
            chk("bp out_valid", out_valid, 1);
            chk("bp held A", out_result, 3);
        end
        @(posedge clk); #1;
        out_ready = 1;
        wait_acc("bp C");
        repeat (3) begin @(posedge clk); #1; end
        chk("bp delivered", delivered - d0, 3);
        chk("bp queue empty", sbq.size(), 0);

        // flush with output full, skid empty: D would otherwise be accepted
        out_ready = 0;
        send(64'd1, 64'd2, 4'b0001, 5'd13, 1, 64'd3, 0, 1);
        drive(64'd9, 64'd9, 4'b0010, 5'd14, 1, 64'd18, 0, 1);
        flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("flush1 out_valid", out_valid, 0);
        chk("flush1 in_ready", in_ready, 1);
        out_ready = 1;
        repeat (3) begin @(posedge clk); #1; end

        // flush with output and skid full, coincident transfer of E
        out_ready = 0;
        d0 = delivered;
        send(64'd1, 64'd2, 4'b0001, 5'd15, 1, 64'd3, 0, 1);
        send(64'd4, 64'd4, 4'b0010, 5'd16, 1, 64'd8, 0, 1);
        drive(64'd9, 64'd9, 4'b0010, 5'd17, 1, 64'd18, 0, 1);
        flush = 1; out_ready = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        @(negedge clk);
        chk("flush2 out_valid", out_valid, 0);
        chk("flush2 in_ready", in_ready, 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("flush2 delivered", delivered - d0, 1);

        // asynchronous reset while an output is held
        out_ready = 0;
        send(64'hABCD, 64'h00FF, 4'b0000, 5'd31, 1, 64'h00CD, 0, 1);
        @(negedge clk);
        chk("pre-reset out_valid", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset out_result", out_result, 0);
        chk("async reset out_zero", out_zero, 0);
        chk("async reset out_rd", out_rd, 0);
        chk("async reset out_reg_write", out_reg_write, 0);
        chk("async reset out_illegal", out_illegal, 0);
        @(posedge clk); #1;
        rst_n = 1;
        #1 chk("in_ready after async reset", in_ready, 1);
        @(posedge clk); #1;

        // random stress
        d0 = delivered;
        last_acc = 1; last_fl = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!in_valid || last_acc || last_fl) begin
                in_valid     = ($urandom % 4) != 0;
                in_a         = {$urandom, $urandom};
                in_b         = ($urandom % 4 == 0) ? in_a : {$urandom, $urandom};
                in_alu_ctrl  = ctrls[$urandom % 6];
                in_rd        = 5'($urandom);
                in_reg_write = 1'($urandom);
                exp_cur      = model(in_a, in_b, in_alu_ctrl, in_rd, in_reg_write);
            end
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 64) == 0;
            @(negedge clk);
            last_acc = in_valid && in_ready;
            last_fl  = flush;
            @(posedge clk); #1;
        end
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (4) begin @(posedge clk); #1; end
        chk("stress queue drained", sbq.size(), 0);
        chk("stress made progress", (delivered - d0) > 2000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
